// File: rtl/da_pkg.sv
// da_pkg: shared FSM states and width derivations for the distributed-arithmetic MAC
package da_pkg;
  typedef enum logic [1:0] {IDLE, RUN, OFFSET, DONE} state_t;
  function automatic int lut_w(input int wb, input int k);
    return wb + $clog2(k);
  endfunction
  function automatic int acc_w(input int wl, input int wa);
    return wl + 1 + wa;
  endfunction
  function automatic int cnt_w(input int wa);
    return wa > 1 ? $clog2(wa) : 1;
  endfunction
endpackage

// File: rtl/da_bit_slicer.sv
// da_bit_slicer: activation shift register with offset-binary LUT address and sign generation
module da_bit_slicer #(
  parameter int DATA_WIDTH_A = 8,
  parameter int K = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic                             run,
  input  logic                             offs,
  input  logic [K-1:0][DATA_WIDTH_A-1:0]   a_in,
  output logic [K-2:0]                     addr_array,
  output logic                             neg
);
  logic [K-1:0][DATA_WIDTH_A-1:0] sr;
  logic [K-1:0] msb;
  for (genvar k = 0; k < K; k++) begin : g_msb
    assign msb[k] = sr[k][DATA_WIDTH_A-1];
  end
  // load the vector on accept, then move the next lower bit into the MSB each RUN cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr <= '0;
    else if (load) sr <= a_in;
    else if (run) for (int k = 0; k < K; k++) sr[k] <= sr[k] << 1;
  end
  // element 0 is the LUT reference sign; OFFSET forces the all-zero-bits pattern
  always_comb begin
    addr_array = run ? ~(msb[K-1:1] ^ {(K-1){msb[0]}}) : offs ? '1 : '0;
    neg = run ? ~msb[0] : 1'b1;
  end
endmodule

// File: rtl/da_mac_ctrl.sv
// da_mac_ctrl: bit-serial distributed-arithmetic dot-product controller driving an external LUT
module da_mac_ctrl
  import da_pkg::*;
#(
  parameter int DATA_WIDTH_A = 8,
  parameter int DATA_WIDTH_B = 8,
  parameter int K = 4,
  parameter int LUT_WIDTH = lut_w(DATA_WIDTH_B, K),
  parameter int ACC_WIDTH = acc_w(LUT_WIDTH, DATA_WIDTH_A)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [K-1:0][DATA_WIDTH_A-1:0]  a_in,
  output logic                            gen_done,
  output logic [K-2:0]                    addr_array,
  input  logic signed [LUT_WIDTH:0]       lut_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [ACC_WIDTH-1:0]     y_out,
  output logic                            busy
);
  localparam int CW = cnt_w(DATA_WIDTH_A);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic signed [ACC_WIDTH-1:0] acc, lut_ext, term;
  logic accept, first, neg;
  da_bit_slicer #(.DATA_WIDTH_A(DATA_WIDTH_A), .K(K)) u_slicer (
    .clk(clk), .rst(rst), .load(accept), .run(state == RUN), .offs(state == OFFSET),
    .a_in(a_in), .addr_array(addr_array), .neg(neg)
  );
  assign lut_ext = ACC_WIDTH'(lut_out);
  assign term = neg ? -lut_ext : lut_ext;
  assign first = cnt == CW'(DATA_WIDTH_A - 1);
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= nxt;
  end
  // bit counter and accumulator: MSB weight is negative, then shift-and-add, then offset correction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      if (accept) cnt <= CW'(DATA_WIDTH_A - 1);
      else if (state == RUN) cnt <= cnt - 1'b1;
      if (state == RUN) acc <= first ? -term : (acc <<< 1) + term;
      else if (state == OFFSET) acc <= acc + term;
    end
  end
  // next state and handshake outputs
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = in_valid ? RUN : IDLE;
      RUN:     nxt = cnt == '0 ? OFFSET : RUN;
      OFFSET:  nxt = DONE;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
    in_ready = state == IDLE;
    accept = in_valid && state == IDLE;
    busy = state != IDLE;
    gen_done = state == RUN || state == OFFSET;
    out_valid = state == DONE;
    y_out = acc;
  end
endmodule
